// File: rtl/block_ram_sdp_clr.sv
// Simple-dual-port block RAM with per-byte write enables, selectable read-during-write
// behaviour, optional output register and a hardware clear sweep.
module block_ram_sdp_clr #(
    parameter int unsigned             ADDR_WIDTH  = 9,
    parameter int unsigned             DATA_WIDTH  = 16,
    parameter int unsigned             BYTE_WIDTH  = 8,
    parameter int unsigned             OUT_REG     = 0,
    parameter int unsigned             RDW_MODE    = 0,
    parameter string                   INIT_FILE   = "",
    parameter int unsigned             INIT_HEX    = 1,
    parameter logic [DATA_WIDTH-1:0]   CLEAR_VALUE = '0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                wr_en,
    input  logic [ADDR_WIDTH-1:0]               wr_addr,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    wr_be,
    input  logic                                rd_en,
    input  logic [ADDR_WIDTH-1:0]               rd_addr,
    output logic [DATA_WIDTH-1:0]               rd_data,
    output logic                                rd_valid,
    input  logic                                clr_start,
    output logic                                clr_busy,
    output logic                                clr_done
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("block_ram_sdp_clr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            clr_busy_q, clr_done_q;

    // Effective write port: the sweep owns it while clearing, user writes are dropped.
    logic [NB-1:0]         we_lane;
    logic [ADDR_WIDTH-1:0] we_addr;
    logic [DATA_WIDTH-1:0] we_data;

    always_comb begin
        we_lane = '0;
        we_addr = wr_addr;
        we_data = wr_data;
        if (state_q == StClear) begin
            we_lane = {NB{~reset}};
            we_addr = cnt_q[ADDR_WIDTH-1:0];
            we_data = CLEAR_VALUE;
        end else if (wr_en) begin
            we_lane = wr_be;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we_lane[i]) begin
                mem[we_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= we_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_word;

    always_comb begin
        rd_word = mem[rd_addr];
        if (RDW_MODE != 0 && we_addr == rd_addr) begin
            for (int i = 0; i < NB; i++) begin
                if (we_lane[i]) begin
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = we_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    logic                  rd_valid1_q;
    logic [DATA_WIDTH-1:0] rd_data1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid1_q <= 1'b0;
            rd_data1_q  <= '0;
        end else begin
            rd_valid1_q <= rd_en;
            if (rd_en) rd_data1_q <= rd_word;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  rd_valid2_q;
        logic [DATA_WIDTH-1:0] rd_data2_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_valid2_q <= 1'b0;
                rd_data2_q  <= '0;
            end else begin
                rd_valid2_q <= rd_valid1_q;
                if (rd_valid1_q) rd_data2_q <= rd_data1_q;
            end
        end

        assign rd_valid = rd_valid2_q;
        assign rd_data  = rd_data2_q;
    end else begin : g_no_out_reg
        assign rd_valid = rd_valid1_q;
        assign rd_data  = rd_data1_q;
    end

    // Counter is one bit wider than the address so the terminal compare never aliases.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    clr_done_q <= 1'b0;
                    if (clr_start) begin
                        state_q    <= StClear;
                        cnt_q      <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                StClear: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DEPTH - 1)) begin
                        state_q    <= StDone;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q    <= StIdle;
                    clr_done_q <= 1'b0;
                end
                default: begin
                    state_q    <= StIdle;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_block_ram_sdp_clr.sv
// Scoreboard bench: two instances share stimulus, one with RDW_MODE=0/OUT_REG=0 and one with
// RDW_MODE=1/OUT_REG=1, each checked against a bench-side memory model.
module tb_block_ram_sdp_clr;

    localparam int DEPTH = 16;
    localparam logic [15:0] CLR = 16'h00FF;

    logic        clk, reset;
    logic        wr_en, rd_en, clr_start;
    logic [3:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic [15:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1, clr_busy0, clr_busy1, clr_done0, clr_done1;

    int tests = 0;
    int fails = 0;
    int nvalid0 = 0;
    int nvalid1 = 0;
    logic [15:0] model [DEPTH];
    logic [15:0] exp0_q [$];
    logic [15:0] exp1_q [$];
    logic [15:0] e0, e1;
    bit skip_exp1 = 0;
    bit model_busy = 0;

    block_ram_sdp_clr #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .OUT_REG(0), .RDW_MODE(0),
        .CLEAR_VALUE(CLR)
    ) u_dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .clr_start(clr_start), .clr_busy(clr_busy0), .clr_done(clr_done0)
    );

    block_ram_sdp_clr #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .OUT_REG(1), .RDW_MODE(1),
        .CLEAR_VALUE(CLR)
    ) u_dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .clr_start(clr_start), .clr_busy(clr_busy1), .clr_done(clr_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (rd_valid0 === 1'b1) begin
            nvalid0++;
            tests++;
            if (exp0_q.size() == 0) begin
                fails++;
                $display("FAIL dut0_read: unexpected rd_valid with data %h, required no read", rd_data0);
            end else begin
                e0 = exp0_q.pop_front();
                if (rd_data0 !== e0) begin
                    fails++;
                    $display("FAIL dut0_read: got %h, required %h", rd_data0, e0);
                end
            end
        end
        if (rd_valid1 === 1'b1) begin
            nvalid1++;
            tests++;
            if (exp1_q.size() == 0) begin
                fails++;
                $display("FAIL dut1_read: unexpected rd_valid with data %h, required no read", rd_data1);
            end else begin
                e1 = exp1_q.pop_front();
                if (rd_data1 !== e1) begin
                    fails++;
                    $display("FAIL dut1_read: got %h, required %h", rd_data1, e1);
                end
            end
        end
    end

    function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old_w;
        if (be[0]) r[7:0]  = new_w[7:0];
        if (be[1]) r[15:8] = new_w[15:8];
        return r;
    endfunction

    // One clock of stimulus; expected read data is pushed before the model absorbs the write.
    task automatic cyc(input bit wen, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [1:0] be, input bit ren, input logic [3:0] ra);
        logic [15:0] old_w;
        wr_en = wen; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = ren; rd_addr = ra;
        if (ren) begin
            old_w = model[ra];
            exp0_q.push_back(old_w);
            if (!skip_exp1) begin
                exp1_q.push_back((wen && !model_busy && wa == ra) ? merge(old_w, wd, be) : old_w);
            end
        end
        if (wen && !model_busy) model[wa] = merge(model[wa], wd, be);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && (exp0_q.size() != 0 || exp1_q.size() != 0); i++) idle();
        tests++;
        if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
            fails++;
            $display("FAIL drain: pending reads dut0=%0d dut1=%0d, required 0 and 0",
                     exp0_q.size(), exp1_q.size());
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(i));
        idle();
        drain();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        idle();
        tests++;
        if ({rd_valid0, clr_busy0, clr_done0, rd_valid1, clr_busy1, clr_done1} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {rd_valid0, clr_busy0, clr_done0, rd_valid1, clr_busy1, clr_done1});
        end
        tests++;
        if ({rd_data0, rd_data1} !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: got %h/%h, required 0000/0000", rd_data0, rd_data1);
        end
        reset = 1'b0;
        idle();
    endtask

    task automatic test_write_read();
        cyc(1'b1, 4'd5, 16'hABCD, 2'b11, 1'b0, 4'd0);
        cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5);
        tests++;
        if ({rd_valid0, rd_valid1} !== 2'b10) begin
            fails++;
            $display("FAIL latency_first: valid0/valid1 got %b, required 10", {rd_valid0, rd_valid1});
        end
        idle();
        tests++;
        if ({rd_valid0, rd_valid1} !== 2'b01) begin
            fails++;
            $display("FAIL latency_second: valid0/valid1 got %b, required 01", {rd_valid0, rd_valid1});
        end
        drain();
    endtask

    task automatic test_byte_enable();
        cyc(1'b1, 4'd5, 16'h1234, 2'b01, 1'b0, 4'd0);
        cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5);
        cyc(1'b1, 4'd5, 16'hFFFF, 2'b00, 1'b0, 4'd0);
        cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5);
        idle();
        drain();
    endtask

    task automatic test_rdw();
        cyc(1'b1, 4'd7, 16'h1111, 2'b11, 1'b0, 4'd0);
        cyc(1'b1, 4'd7, 16'h2222, 2'b11, 1'b1, 4'd7);
        cyc(1'b1, 4'd7, 16'h1111, 2'b11, 1'b0, 4'd0);
        cyc(1'b1, 4'd7, 16'h2222, 2'b10, 1'b1, 4'd7);
        // Different addresses must not interact.
        cyc(1'b1, 4'd8, 16'h3333, 2'b11, 1'b1, 4'd7);
        idle();
        drain();
    endtask

    task automatic test_back_to_back();
        int n0, n1;
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 4'(i), 16'h1000 + 16'(i) * 16'h0111, 2'b11, 1'b0, 4'd0);
        n0 = nvalid0;
        n1 = nvalid1;
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(i));
            tests++;
            if ({rd_valid0, rd_valid1} !== {1'b1, i != 0}) begin
                fails++;
                $display("FAIL b2b_valid[%0d]: got %b, required %b", i, {rd_valid0, rd_valid1},
                         {1'b1, i != 0});
            end
        end
        idle();
        tests++;
        if ({rd_valid0, rd_valid1} !== 2'b01) begin
            fails++;
            $display("FAIL b2b_tail: got %b, required 01", {rd_valid0, rd_valid1});
        end
        drain();
        tests++;
        if (nvalid0 - n0 != DEPTH || nvalid1 - n1 != DEPTH) begin
            fails++;
            $display("FAIL b2b_count: got %0d/%0d, required 16/16", nvalid0 - n0, nvalid1 - n1);
        end
    endtask

    task automatic test_clear();
        clr_start = 1'b1;
        idle();
        clr_start = 1'b0;
        model_busy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tests++;
            if ({clr_busy0, clr_done0, clr_busy1, clr_done1} !== {k < 16, k == 16, k < 16, k == 16}) begin
                fails++;
                $display("FAIL clear_flags[%0d]: got %b, required %b", k,
                         {clr_busy0, clr_done0, clr_busy1, clr_done1},
                         {k < 16, k == 16, k < 16, k == 16});
            end
            clr_start = (k == 5);
            if (k == 9) cyc(1'b1, 4'd3, 16'h5555, 2'b11, 1'b0, 4'd0);
            else        idle();
        end
        clr_start = 1'b0;
        model_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = CLR;
        read_all();
    endtask

    task automatic test_reset_mid_sweep();
        int dones;
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 4'(i), 16'hAAAA, 2'b11, 1'b0, 4'd0);
        clr_start = 1'b1;
        idle();
        clr_start = 1'b0;
        model_busy = 1'b1;
        for (int i = 0; i < 5; i++) model[i] = CLR;
        repeat (4) idle();
        // This read completes on the latency-1 instance but is in flight on the other at reset.
        skip_exp1 = 1'b1;
        cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd0);
        skip_exp1 = 1'b0;
        reset = 1'b1;
        idle();
        tests++;
        if ({clr_busy0, clr_done0, rd_valid0, clr_busy1, clr_done1, rd_valid1} !== 6'b0) begin
            fails++;
            $display("FAIL midreset_flags: got %b, required 000000",
                     {clr_busy0, clr_done0, rd_valid0, clr_busy1, clr_done1, rd_valid1});
        end
        tests++;
        if ({rd_data0, rd_data1} !== 32'h0) begin
            fails++;
            $display("FAIL midreset_data: got %h/%h, required 0000/0000", rd_data0, rd_data1);
        end
        reset = 1'b0;
        model_busy = 1'b0;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            idle();
            if (clr_done0 !== 1'b0 || clr_done1 !== 1'b0 || clr_busy0 !== 1'b0) dones++;
        end
        tests++;
        if (dones != 0) begin
            fails++;
            $display("FAIL midreset_no_done: got %0d active cycles, required 0", dones);
        end
        read_all();
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0; clr_start = 1'b0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_rdw();
        test_back_to_back();
        test_clear();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
